// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH valid-tagged slots with global
// stall, per-slot flush (bubble insert) and saturating stall/flush event counters.
`timescale 1ns/1ps

module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CTRL_W      = 8,
    parameter int unsigned       DEPTH       = 1,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter bit                DATA_CLEAR  = 1'b1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              stall_i,
    input  logic [DEPTH-1:0]  flush_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DEPTH-1:0]  slot_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CTRL_W-1:0] r_ctrl [DEPTH];

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    // Source of each slot: slot 0 from upstream, slot k from the pre-edge slot k-1.
    logic [DEPTH-1:0]  w_src_valid;
    logic [DATA_W-1:0] w_src_data [DEPTH];
    logic [CTRL_W-1:0] w_src_ctrl [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign w_src_valid[g] = valid_i;
            assign w_src_data[g]  = data_i;
            assign w_src_ctrl[g]  = ctrl_i;
        end else begin : g_chain
            assign w_src_valid[g] = r_valid[g-1];
            assign w_src_data[g]  = r_data[g-1];
            assign w_src_ctrl[g]  = r_ctrl[g-1];
        end
    end

    // Per-slot priority: reset > flush > stall > load. A flushed slot ignores stall,
    // while its neighbours still hold or shift according to their own flush bit.
    // NOTE: the slot array is a handful of flops, not a RAM, so resetting every entry
    // is cheap and guarantees no stale ctrl word ever reaches the next stage.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst_i) begin
                // NOTE: sequential state uses non-blocking assignments so every slot
                // samples its neighbour's pre-edge value regardless of loop order.
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_ctrl[k]  <= CTRL_BUBBLE;
            end else if (flush_i[k]) begin
                r_valid[k] <= 1'b0;
                r_ctrl[k]  <= CTRL_BUBBLE;
                r_data[k]  <= DATA_CLEAR ? '0 : w_src_data[k];
            end else if (!stall_i) begin
                r_valid[k] <= w_src_valid[k];
                r_data[k]  <= w_src_data[k];
                r_ctrl[k]  <= w_src_ctrl[k];
            end
        end
    end

    // Event counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((|flush_i) && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign valid_o      = r_valid[DEPTH-1];
    assign data_o       = r_data[DEPTH-1];
    assign ctrl_o       = r_ctrl[DEPTH-1];
    assign slot_valid_o = r_valid;
    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: three configurations driven in lockstep,
// directed scenarios with constant expectations plus randomized traffic against a model.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

    localparam int          NU          = 3;
    localparam int          DEP  [NU]   = '{3, 2, 1};
    localparam bit          CLR  [NU]   = '{1'b1, 1'b1, 1'b0};
    localparam logic [7:0]  BUB  [NU]   = '{8'h00, 8'hA5, 8'h3C};
    localparam int          CMAX [NU]   = '{65535, 65535, 15};

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic [7:0]  ctrl;
    logic        stall;
    logic [2:0]  flush;

    logic        d3_valid, d2_valid, d1_valid;
    logic [31:0] d3_data, d2_data, d1_data;
    logic [7:0]  d3_ctrl, d2_ctrl, d1_ctrl;
    logic [2:0]  d3_slot;
    logic [1:0]  d2_slot;
    logic [0:0]  d1_slot;
    logic [15:0] d3_sc, d3_fc, d2_sc, d2_fc;
    logic [3:0]  d1_sc, d1_fc;

    int errors = 0;
    int checks = 0;

    // Reference model state: per unit, per slot.
    bit          m_v [NU][8];
    logic [31:0] m_d [NU][8];
    logic [7:0]  m_c [NU][8];
    int          m_sc [NU];
    int          m_fc [NU];

    // Uniform view of the three DUTs' outputs.
    logic        o_valid [NU];
    logic [31:0] o_data  [NU];
    logic [7:0]  o_ctrl  [NU];
    logic [2:0]  o_slot  [NU];
    int          o_sc    [NU];
    int          o_fc    [NU];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .CTRL_BUBBLE(8'h00),
                     .DATA_CLEAR(1'b1), .CNT_W(16)) u_d3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .ctrl_i(ctrl),
        .stall_i(stall), .flush_i(flush[2:0]),
        .valid_o(d3_valid), .data_o(d3_data), .ctrl_o(d3_ctrl), .slot_valid_o(d3_slot),
        .stall_cnt_o(d3_sc), .flush_cnt_o(d3_fc));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(2), .CTRL_BUBBLE(8'hA5),
                     .DATA_CLEAR(1'b1), .CNT_W(16)) u_d2 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .ctrl_i(ctrl),
        .stall_i(stall), .flush_i(flush[1:0]),
        .valid_o(d2_valid), .data_o(d2_data), .ctrl_o(d2_ctrl), .slot_valid_o(d2_slot),
        .stall_cnt_o(d2_sc), .flush_cnt_o(d2_fc));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(1), .CTRL_BUBBLE(8'h3C),
                     .DATA_CLEAR(1'b0), .CNT_W(4)) u_d1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .ctrl_i(ctrl),
        .stall_i(stall), .flush_i(flush[0:0]),
        .valid_o(d1_valid), .data_o(d1_data), .ctrl_o(d1_ctrl), .slot_valid_o(d1_slot),
        .stall_cnt_o(d1_sc), .flush_cnt_o(d1_fc));

    always_comb begin
        o_valid[0] = d3_valid; o_data[0] = d3_data; o_ctrl[0] = d3_ctrl;
        o_slot[0]  = d3_slot;  o_sc[0] = int'(d3_sc); o_fc[0] = int'(d3_fc);
        o_valid[1] = d2_valid; o_data[1] = d2_data; o_ctrl[1] = d2_ctrl;
        o_slot[1]  = {1'b0, d2_slot}; o_sc[1] = int'(d2_sc); o_fc[1] = int'(d2_fc);
        o_valid[2] = d1_valid; o_data[2] = d1_data; o_ctrl[2] = d1_ctrl;
        o_slot[2]  = {2'b00, d1_slot}; o_sc[2] = int'(d1_sc); o_fc[2] = int'(d1_fc);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance every unit of the model by one edge using the currently driven inputs.
    // Slots are visited from the tail so slot k still sees slot k-1's old contents.
    task automatic model_step();
        for (int u = 0; u < NU; u++) begin
            for (int k = DEP[u] - 1; k >= 0; k--) begin
                bit          sv;
                logic [31:0] sd;
                logic [7:0]  sc;
                if (k == 0) begin
                    sv = valid; sd = data; sc = ctrl;
                end else begin
                    sv = m_v[u][k-1]; sd = m_d[u][k-1]; sc = m_c[u][k-1];
                end
                if (rst) begin
                    m_v[u][k] = 1'b0; m_d[u][k] = '0; m_c[u][k] = BUB[u];
                end else if (flush[k]) begin
                    m_v[u][k] = 1'b0; m_c[u][k] = BUB[u];
                    m_d[u][k] = CLR[u] ? 32'h0 : sd;
                end else if (!stall) begin
                    m_v[u][k] = sv; m_d[u][k] = sd; m_c[u][k] = sc;
                end
            end
            if (rst) begin
                m_sc[u] = 0;
                m_fc[u] = 0;
            end else begin
                if (stall && m_sc[u] < CMAX[u]) m_sc[u]++;
                if ((flush & 3'((1 << DEP[u]) - 1)) != 3'b000 && m_fc[u] < CMAX[u]) m_fc[u]++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input logic [7:0] c,
                         input bit s, input logic [2:0] f, input bit r);
        valid = v; data = d; ctrl = c; stall = s; flush = f; rst = r;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hDEAD_BEEF, 8'h77, 1'b0, 3'b000, 1'b1);
        tick();
        tick();
        checks++; if (d3_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", d3_valid); end
        checks++; if (d3_slot !== 3'b000) begin errors++; $display("FAIL reset_slot got=%b exp=000", d3_slot); end
        checks++; if (d3_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", d3_ctrl); end
        checks++; if (d3_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", d3_data); end
        checks++; if (d3_sc !== 16'h0 || d3_fc !== 16'h0) begin
            errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", d3_sc, d3_fc); end
        checks++; if (d2_ctrl !== 8'hA5) begin errors++; $display("FAIL reset_bubble_d2 got=%h exp=a5", d2_ctrl); end
    endtask

    task automatic test_latency();
        for (int i = 1; i <= 6; i++) begin
            drive(i <= 4, 32'(i), 8'(i), 1'b0, 3'b000, 1'b0);
            tick();
            if (i >= 3) begin
                checks++;
                if (d3_valid !== 1'b1 || d3_data !== 32'(i - 2)) begin
                    errors++;
                    $display("FAIL latency_edge%0d got=%b/%h exp=1/%h", i, d3_valid, d3_data, i - 2);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(7 - i), 8'h10, 1'b0, 3'b000, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 8'h00, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (d3_data !== 32'd7 || d3_slot !== 3'b111) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h/%b exp=7/111", i, d3_data, d3_slot);
            end
        end
        checks++; if (d3_sc !== 16'd4) begin errors++; $display("FAIL stall_cnt got=%0d exp=4", d3_sc); end
        drive(1'b0, 32'h0, 8'h00, 1'b0, 3'b000, 1'b0);
        tick();
        checks++;
        if (d3_data !== 32'd6 || d3_slot !== 3'b110) begin
            errors++; $display("FAIL stall_resume got=%h/%b exp=6/110", d3_data, d3_slot);
        end
    endtask

    task automatic test_flush_during_stall();
        drive(1'b1, 32'hB0B0_0001, 8'h11, 1'b0, 3'b000, 1'b0);
        tick();
        drive(1'b1, 32'hA0A0_0002, 8'h22, 1'b0, 3'b000, 1'b0);
        tick();
        drive(1'b1, 32'hFFFF_FFFF, 8'hEE, 1'b1, 3'b001, 1'b0);
        tick();
        checks++; if (d2_slot !== 2'b10) begin errors++; $display("FAIL fs_slot got=%b exp=10", d2_slot); end
        checks++;
        if (d2_data !== 32'hB0B0_0001 || d2_ctrl !== 8'h11) begin
            errors++; $display("FAIL fs_tail_hold got=%h/%h exp=b0b00001/11", d2_data, d2_ctrl);
        end
        checks++; if (d2_fc !== 16'd1) begin errors++; $display("FAIL fs_flush_cnt got=%0d exp=1", d2_fc); end
        drive(1'b0, 32'h0, 8'h00, 1'b0, 3'b000, 1'b0);
        tick();
        checks++;
        if (d2_valid !== 1'b0 || d2_data !== 32'h0 || d2_ctrl !== 8'hA5) begin
            errors++; $display("FAIL fs_bubble got=%b/%h/%h exp=0/0/a5", d2_valid, d2_data, d2_ctrl);
        end
    endtask

    task automatic test_flush_keep_data();
        drive(1'b1, 32'h100, 8'h5A, 1'b0, 3'b001, 1'b0);
        tick();
        checks++;
        if (d1_valid !== 1'b0 || d1_ctrl !== 8'h3C || d1_data !== 32'h100) begin
            errors++; $display("FAIL flush_dc0 got=%b/%h/%h exp=0/3c/100", d1_valid, d1_ctrl, d1_data);
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 32'h0, 8'h00, 1'b0, 3'b000, 1'b1);
        tick();
        drive(1'b0, 32'h0, 8'h00, 1'b1, 3'b000, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (d1_sc !== 4'((i > 15) ? 15 : i)) begin
                errors++; $display("FAIL sat_cycle%0d got=%0d exp=%0d", i, d1_sc, (i > 15) ? 15 : i);
            end
        end
        checks++; if (d3_sc !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", d3_sc); end
        drive(1'b0, 32'h0, 8'h00, 1'b0, 3'b000, 1'b1);
        tick();
        checks++; if (d1_sc !== 4'h0) begin errors++; $display("FAIL sat_reset got=%0d exp=0", d1_sc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
                  $urandom_range(0, 9) < 3,
                  ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                  $urandom_range(0, 59) == 0);
            tick();
            for (int u = 0; u < NU; u++) begin
                logic [2:0] es;
                int         t;
                es = '0;
                for (int k = 0; k < DEP[u]; k++) es[k] = m_v[u][k];
                t = DEP[u] - 1;
                checks++;
                if (o_valid[u] !== m_v[u][t] || o_data[u] !== m_d[u][t] || o_ctrl[u] !== m_c[u][t]
                    || o_slot[u] !== es) begin
                    errors++;
                    $display("FAIL rand_out u%0d n%0d got=%b/%h/%h/%b exp=%b/%h/%h/%b", u, n,
                             o_valid[u], o_data[u], o_ctrl[u], o_slot[u],
                             m_v[u][t], m_d[u][t], m_c[u][t], es);
                end
                checks++;
                if (o_sc[u] != m_sc[u] || o_fc[u] != m_fc[u]) begin
                    errors++;
                    $display("FAIL rand_cnt u%0d n%0d got=%0d/%0d exp=%0d/%0d", u, n,
                             o_sc[u], o_fc[u], m_sc[u], m_fc[u]);
                end
            end
        end
    endtask

    initial begin
        drive(1'b0, 32'h0, 8'h00, 1'b0, 3'b000, 1'b1);
        for (int u = 0; u < NU; u++) begin
            m_sc[u] = 0;
            m_fc[u] = 0;
            for (int k = 0; k < 8; k++) begin
                m_v[u][k] = 1'b0; m_d[u][k] = '0; m_c[u][k] = BUB[u];
            end
        end
        test_reset();
        test_latency();
        test_stall();
        test_flush_during_stall();
        test_flush_keep_data();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
